// File: rtl/lcd_cmd_arbiter.sv
// lcd_cmd_arbiter
// Round-robin arbiter that funnels command words from two requesters into a
// single LCD write engine. One command is in flight at a time. Each completion
// (lcd_ok) is followed by a fixed idle gap before the next grant.
//
// Optional feature: define LCD_ARB_TIMEOUT_EN to bound the WAIT state to
// TIMEOUT cycles. On expiry the sticky err flag is set and the transfer is
// closed with an ack as if the engine had answered.
//
// Reset is synchronous and active-low on rst.

module lcd_cmd_arbiter #(
   parameter int GAP_CYCLES = 3,
   parameter int TIMEOUT    = 200000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0,
   input  logic [25:0] din0,
   output logic        ack0,
   input  logic        req1,
   input  logic [25:0] din1,
   output logic        ack1,
   output logic [25:0] lcd_din,
   output logic        lcd_intr,
   input  logic        lcd_ok,
   output logic        busy,
   output logic        owner,
   output logic        err
);

   localparam int GW = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);
   localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   // Reject parameter values that would make the gap or timeout meaningless.
   if (GAP_CYCLES < 0 || TIMEOUT < 1) begin : g_bad_param
      $error("lcd_cmd_arbiter: GAP_CYCLES must be >= 0 and TIMEOUT >= 1");
   end

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_GAP   = 2'd3
   } state_t;

   state_t          state_q,    state_d;
   logic [25:0]     lcd_din_q,  lcd_din_d;
   logic            lcd_intr_q, lcd_intr_d;
   logic            ack0_q,     ack0_d;
   logic            ack1_q,     ack1_d;
   logic            owner_q,    owner_d;
   logic            ptr_q,      ptr_d;      // requester favoured on a tie
   logic [GW-1:0]   gap_cnt_q,  gap_cnt_d;
   logic            busy_q,     busy_d;
   logic            any_req_s;
   logic            gnt_s;
   logic            done_s;
`ifdef LCD_ARB_TIMEOUT_EN
   logic [TW-1:0]   tmo_cnt_q,  tmo_cnt_d;
   logic            err_q,      err_d;
   logic            tmo_hit_s;
`endif

   // Pick the requester to grant: round-robin on a tie, otherwise whoever asks.
   always_comb begin
      any_req_s = req0 | req1;
      if (req0 && req1) begin
         gnt_s = ptr_q;
      end else if (req1) begin
         gnt_s = 1'b1;
      end else begin
         gnt_s = 1'b0;
      end
   end

   // Next-state and registered-output logic for the arbitration FSM.
   always_comb begin
      state_d    = state_q;
      lcd_din_d  = lcd_din_q;
      lcd_intr_d = 1'b0;
      ack0_d     = 1'b0;
      ack1_d     = 1'b0;
      owner_d    = owner_q;
      ptr_d      = ptr_q;
      gap_cnt_d  = gap_cnt_q;
      done_s     = 1'b0;
`ifdef LCD_ARB_TIMEOUT_EN
      tmo_cnt_d  = tmo_cnt_q;
      err_d      = err_q;
      tmo_hit_s  = (tmo_cnt_q == TW'(TIMEOUT - 1));
`endif

      case (state_q)
         ST_IDLE: begin
            if (any_req_s) begin
               state_d    = ST_ISSUE;
               owner_d    = gnt_s;
               lcd_din_d  = gnt_s ? din1 : din0;
               lcd_intr_d = 1'b1;    // high for the single ISSUE cycle
            end else begin
               state_d    = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            state_d = ST_WAIT;
`ifdef LCD_ARB_TIMEOUT_EN
            tmo_cnt_d = {TW{1'b0}};
`endif
         end
         ST_WAIT: begin
            if (lcd_ok) begin
               done_s = 1'b1;        // lcd_ok wins over a coincident timeout
`ifdef LCD_ARB_TIMEOUT_EN
            end else if (tmo_hit_s) begin
               done_s = 1'b1;
               err_d  = 1'b1;
`endif
            end else begin
               done_s = 1'b0;
`ifdef LCD_ARB_TIMEOUT_EN
               tmo_cnt_d = tmo_cnt_q + TW'(1);
`endif
            end
         end
         ST_GAP: begin
            if (gap_cnt_q == {GW{1'b0}}) begin
               state_d   = ST_IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q - GW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Close the transfer: ack the owner, hand priority to the other side.
      if (done_s) begin
         state_d   = ST_GAP;
         ack0_d    = ~owner_q;
         ack1_d    = owner_q;
         ptr_d     = ~owner_q;
         gap_cnt_d = GW'(GAP_CYCLES);
      end else begin
         ptr_d     = ptr_d;
      end

      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         lcd_din_q  <= 26'd0;
         lcd_intr_q <= 1'b0;
         ack0_q     <= 1'b0;
         ack1_q     <= 1'b0;
         owner_q    <= 1'b0;
         ptr_q      <= 1'b0;
         gap_cnt_q  <= {GW{1'b0}};
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         lcd_din_q  <= lcd_din_d;
         lcd_intr_q <= lcd_intr_d;
         ack0_q     <= ack0_d;
         ack1_q     <= ack1_d;
         owner_q    <= owner_d;
         ptr_q      <= ptr_d;
         gap_cnt_q  <= gap_cnt_d;
         busy_q     <= busy_d;
      end
   end

`ifdef LCD_ARB_TIMEOUT_EN
   // WAIT-state timeout counter and sticky error flag.
   always_ff @(posedge clk) begin
      if (!rst) begin
         tmo_cnt_q <= {TW{1'b0}};
         err_q     <= 1'b0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
         err_q     <= err_d;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   assign lcd_din  = lcd_din_q;
   assign lcd_intr = lcd_intr_q;
   assign ack0     = ack0_q;
   assign ack1     = ack1_q;
   assign owner    = owner_q;
   assign busy     = busy_q;

endmodule

// File: doc/lcd_cmd_arbiter.md
LCD_CMD_ARBITER -- requirements
Module: lcd_cmd_arbiter

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 3: idle cycles inserted after each lcd_ok before the next grant.
REQ-002 SHALL have parameter TIMEOUT, default 200000: WAIT-state cycle limit (used only with LCD_ARB_TIMEOUT_EN).
REQ-003 SHALL have port clk  input  1  main clock, 22.1184 MHz.
REQ-004 SHALL have port rst  input  1  reset; one clock, synchronous, active-low.
REQ-005 SHALL have port req0  input  1  requester 0 command request.
REQ-006 SHALL have port din0  input  26  requester 0 command {17b delay, 1b rs, 8b data}.
REQ-007 SHALL have port ack0  output  1  one-cycle pulse when requester 0's command completes.
REQ-008 SHALL have ports req1, din1 and ack1, identical to req0, din0 and ack0, for requester 1.
REQ-009 SHALL have port lcd_din  output  26  command word presented to the LCD write engine.
REQ-010 SHALL have port lcd_intr  output  1  one-cycle start pulse to the LCD write engine.
REQ-011 SHALL have port lcd_ok  input  1  completion pulse from the LCD write engine.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-013 SHALL have port owner  output  1  index of the last-granted requester.
REQ-014 SHALL have port err  output  1  sticky timeout flag.

Function
REQ-015 SHALL implement the FSM states IDLE, ISSUE, WAIT and GAP.
REQ-016 In IDLE with any req high at a clock edge, the FSM SHALL grant one requester, latch its din into lcd_din, set owner, and enter ISSUE at that edge.
REQ-017 Arbitration SHALL be round-robin: when both requesters are high, the one not granted last wins; the pointer resets to favour requester 0.
REQ-018 A single active requester SHALL be granted regardless of the pointer.
REQ-019 lcd_intr SHALL be high exactly one cycle, in ISSUE; ISSUE SHALL go to WAIT unconditionally.
REQ-020 lcd_din SHALL be registered and SHALL hold stable from grant until the next grant.
REQ-021 In WAIT, lcd_ok high SHALL pulse the owner's ack for one cycle, toggle the pointer, load the gap counter with GAP_CYCLES, and enter GAP.
REQ-022 GAP SHALL decrement the counter and enter IDLE when it reaches 0.
REQ-023 The minimum spacing from lcd_ok to the next lcd_intr SHALL be GAP_CYCLES+2 cycles.
REQ-024 lcd_ok outside WAIT SHALL be ignored, with no ack and no state change.
REQ-025 Requesters SHALL hold req and din stable until ack; req dropped after grant SHALL NOT abort the transfer.
REQ-026 A requester SHALL NOT see ack without having been granted.
REQ-027 A req held high after ack SHALL be treated as a new request.
REQ-028 ack0 and ack1 SHALL never be high in the same cycle.
REQ-029 busy SHALL equal (state != IDLE).

Reset
REQ-030 rst low at a clock edge SHALL force: state IDLE, lcd_intr 0, ack0/ack1 0, lcd_din 0, owner 0, pointer favouring requester 0, gap counter 0, busy 0, err 0.
REQ-031 Reset mid-transfer SHALL drop the transfer silently, with no ack.
REQ-032 A lcd_ok arriving after reset release SHALL be ignored.

Configuration
REQ-033 With macro LCD_ARB_TIMEOUT_EN defined, a counter SHALL clear on WAIT entry and increment each WAIT cycle.
REQ-034 With LCD_ARB_TIMEOUT_EN, reaching TIMEOUT without lcd_ok SHALL set err (sticky until reset), pulse the owner's ack, and enter GAP.
REQ-035 With LCD_ARB_TIMEOUT_EN, lcd_ok and timeout in the same cycle SHALL be treated as lcd_ok, with err unchanged.
REQ-036 Without LCD_ARB_TIMEOUT_EN, err SHALL be tied to 0, no timeout counter SHALL exist, and WAIT SHALL wait indefinitely.

Verification
REQ-037 SHALL test: req0=1, din0=26'h0162B38 at edge k -> lcd_din=26'h0162B38 and lcd_intr=1 in the cycle after edge k only; lcd_ok at edge k+10 -> ack0 pulse; next lcd_intr no earlier than edge k+15.
REQ-038 SHALL test: req0 and req1 both held, lcd_ok returned 5 cycles after each lcd_intr -> grant order 0,1,0,1; owner alternates; acks never overlap.
REQ-039 SHALL test: lcd_ok pulsed in IDLE and in GAP -> no ack, state unchanged.
REQ-040 SHALL test: rst low while in WAIT, then lcd_ok after release -> no ack, busy=0, owner=0.
REQ-041 SHALL test: with LCD_ARB_TIMEOUT_EN and TIMEOUT=16, no lcd_ok -> ack pulse 16 cycles after WAIT entry, err=1 held until rst; without the macro -> busy stays 1, err=0.
